// File: rtl/mem_stage_sized_if.sv
// Purpose : EX->MEM request bundle and MEM->WB result bundle for mem_stage_sized.
// Latency : n/a (wiring only).
// Backpr. : stall holds the stage, flush kills the op presented in the same cycle.
//
// Signals (request, driven by master):
//   flush, stall, in_valid, mem_write, mem_read, mem_size[1:0], mem_signed,
//   alu_res[DATA_W], rd_rq_in[DATA_W]
// Signals (result, driven by slave):
//   out_valid, alu_out[DATA_W], wr_reg_data_out[DATA_W], misalign
interface mem_stage_sized_if #(
  parameter int DATA_W = 32
);
  // request side
  logic              flush;
  logic              stall;
  logic              in_valid;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        mem_size;
  logic              mem_signed;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] rd_rq_in;

  // result side
  logic              out_valid;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] wr_reg_data_out;
  logic              misalign;

  // EX side (or a bench) presents ops and observes results
  modport master (
    output flush, stall, in_valid, mem_write, mem_read, mem_size, mem_signed,
           alu_res, rd_rq_in,
    input  out_valid, alu_out, wr_reg_data_out, misalign
  );

  // MEM stage consumes ops and produces registered results
  modport slave (
    input  flush, stall, in_valid, mem_write, mem_read, mem_size, mem_signed,
           alu_res, rd_rq_in,
    output out_valid, alu_out, wr_reg_data_out, misalign
  );
endinterface

// File: rtl/mem_stage_sized.sv
// Purpose : pipeline MEM stage with on-chip sync data RAM, byte/half/word access.
// Latency : 1 cycle from accepted op to registered result (out_valid).
// Backpr. : stall holds all state incl. RAM read address; flush beats stall and kills.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-low; clears result registers, not the RAM
//   bus  - mem_stage_sized_if.slave: request (flush/stall/in_valid/mem_write/
//          mem_read/mem_size/mem_signed/alu_res/rd_rq_in) and registered result
//          (out_valid/alu_out/wr_reg_data_out/misalign)
//
// Notes:
//   - Word index is alu_res[ADDR_W+1:2]; upper address bits are ignored (wrap).
//   - Store wins when mem_read and mem_write are both set.
//   - DATA_W is expected to be 32 (four byte lanes).
module mem_stage_sized #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_sized_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  // ------------------------------------------------------------------
  // Request decode
  // ------------------------------------------------------------------
  logic              accept;
  logic              is_mem;
  logic              is_store;
  logic              is_load;
  logic              aligned;
  logic              mis;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic              wr_en;
  logic              rd_en;
  logic [3:0]        wstrb;
  logic [DATA_W-1:0] wdata;

  // rst gates acceptance so an op presented while reset is held never
  // reaches the RAM, even though the RAM itself has no reset.
  assign accept   = rst & bus.in_valid & ~bus.stall & ~bus.flush;
  assign is_mem   = bus.mem_read | bus.mem_write;
  assign is_store = bus.mem_write;
  assign is_load  = bus.mem_read & ~bus.mem_write;
  assign lane     = bus.alu_res[1:0];
  assign idx      = bus.alu_res[ADDR_W+1:2];

  always_comb begin
    aligned = 1'b1;
    case (bus.mem_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.alu_res[0];
      default: aligned = (bus.alu_res[1:0] == 2'b00);
    endcase
  end

  assign mis   = is_mem & ~aligned;
  assign wr_en = accept & is_store & aligned;
  assign rd_en = accept & is_load & aligned;

  // Store data is replicated across lanes so the strobe alone picks the
  // destination lane(s); no barrel shift needed on the write side.
  always_comb begin
    wstrb = 4'b0000;
    wdata = bus.rd_rq_in;
    case (bus.mem_size)
      2'b00: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{bus.rd_rq_in[7:0]}};
      end
      2'b01: begin
        wstrb = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.rd_rq_in[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = bus.rd_rq_in;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Data RAM: byte-lane write, registered read. No reset on purpose so it
  // maps onto block RAM; a store that reached its edge survives reset.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          ram[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register only loads on an accepted load, so it holds through stalls.
  // A store on the previous accepted op has already landed in the array, which
  // gives read-after-write on back-to-back ops without a bypass.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_word <= ram[idx];
    end
  end

  // ------------------------------------------------------------------
  // Result registers
  // ------------------------------------------------------------------
  logic              out_valid_q;
  logic              misalign_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] res_q;     // non-load writeback value (alu_res or 0)
  logic              load_q;    // result comes from rd_word
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              signed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      alu_q       <= '0;
      res_q       <= '0;
      load_q      <= 1'b0;
      lane_q      <= 2'b00;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
    end else if (bus.flush) begin
      // Data registers are left alone; only the valid/flag bits matter.
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else if (!bus.stall) begin
      out_valid_q <= bus.in_valid;
      misalign_q  <= bus.in_valid & mis;
      if (bus.in_valid) begin
        alu_q    <= bus.alu_res;
        res_q    <= mis ? '0 : bus.alu_res;
        load_q   <= is_load & aligned;
        lane_q   <= lane;
        size_q   <= bus.mem_size;
        signed_q <= bus.mem_signed;
      end
    end
  end

  // ------------------------------------------------------------------
  // Load alignment / extension. Built purely from registered state, so the
  // writeback value still changes only at clock edges (and on reset, where
  // load_q=0 forces the res_q path to zero).
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_val;

  assign shifted = rd_word >> {lane_q, 3'b000};

  always_comb begin
    load_val = shifted;
    case (size_q)
      2'b00:   load_val = {{(DATA_W-8){signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{(DATA_W-16){signed_q & shifted[15]}}, shifted[15:0]};
      // aligned word: lane_q is 0, so shifted equals rd_word
      default: load_val = shifted;
    endcase
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.misalign        = misalign_q;
  assign bus.alu_out         = alu_q;
  assign bus.wr_reg_data_out = load_q ? load_val : res_q;

endmodule
